ram_readout: RTL and testbench



---
 rtl/ram_readout.sv | 126 ++++++++++++
 tb/tb_ram_readout.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_readout.sv
// ram_readout: arms a capture RAM, waits for it to fill, then streams every
// word out in ascending address order over a valid/ready handshake.
module ram_readout #(
    parameter int NB_ADDR    = 11,
    parameter int NB_DATA    = 16,
    parameter int RD_LATENCY = 3
) (
    input  logic               clock,
    input  logic               cpu_reset,
    input  logic               in_start,
    input  logic               in_abort,
    input  logic               in_full_from_ram,
    input  logic [NB_DATA-1:0] in_data_from_ram,
    input  logic               in_ready,
    output logic               out_log_ram_run,
    output logic [NB_ADDR-1:0] out_ram_read_addr,
    output logic [NB_DATA-1:0] out_data,
    output logic               out_valid,
    output logic               out_busy,
    output logic               out_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOG,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [3:0]         LAT_LAST  = 4'(RD_LATENCY);
    localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;
    localparam logic [NB_ADDR-1:0] ADDR_ONE  = NB_ADDR'(1);

    state_t             state_q;
    logic [3:0]         latCnt_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_DATA-1:0] data_q;
    logic               run_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    // Control FSM with all outputs registered alongside the state; reset beats
    // abort, abort beats start and transfers.
    always_ff @(posedge clock) begin
        if (cpu_reset) begin
            state_q  <= ST_IDLE;
            latCnt_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            run_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (in_abort) begin
            state_q  <= ST_IDLE;
            latCnt_q <= '0;
            run_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (in_start) begin
                        state_q <= ST_LOG;
                        run_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOG: begin
                    if (in_full_from_ram) begin
                        state_q  <= ST_WAIT;
                        addr_q   <= '0;
                        latCnt_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (latCnt_q == LAT_LAST) begin
                        state_q <= ST_SEND;
                        data_q  <= in_data_from_ram;
                        valid_q <= 1'b1;
                    end else begin
                        latCnt_q <= latCnt_q + 4'd1;
                    end
                end
                ST_SEND: begin
                    if (in_ready) begin
                        valid_q <= 1'b0;
                        if (addr_q == ADDR_LAST) begin
                            state_q <= ST_DONE;
                            run_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_WAIT;
                            addr_q   <= addr_q + ADDR_ONE;
                            latCnt_q <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    run_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_log_ram_run   = run_q;
    assign out_ram_read_addr = addr_q;
    assign out_data          = data_q;
    assign out_valid         = valid_q;
    assign out_busy          = busy_q;
    assign out_done          = done_q;

endmodule

// File: tb/tb_ram_readout.sv
// tb_ram_readout: drives ram_readout against a latency-3 capture RAM model and
// scores every transfer against the expected word sequence.
module tb_ram_readout;

    localparam int NB_ADDR    = 3;
    localparam int NB_DATA    = 16;
    localparam int RD_LATENCY = 3;
    localparam int DEPTH      = 1 << NB_ADDR;

    logic               clock = 1'b0;
    logic               cpu_reset;
    logic               in_start;
    logic               in_abort;
    logic               in_full_from_ram;
    logic [NB_DATA-1:0] in_data_from_ram;
    logic               in_ready;
    logic               out_log_ram_run;
    logic [NB_ADDR-1:0] out_ram_read_addr;
    logic [NB_DATA-1:0] out_data;
    logic               out_valid;
    logic               out_busy;
    logic               out_done;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;

    int               expIdx       = 0;
    int               doneCount    = 0;
    int               lastXfer     = -1;
    bit               spacingCheck = 1'b0;
    bit               holdPending  = 1'b0;
    logic [NB_DATA-1:0] holdData;
    logic [NB_ADDR-1:0] holdAddr;

    logic [NB_DATA-1:0] ramPipe1;
    logic [NB_DATA-1:0] ramPipe2;

    ram_readout #(
        .NB_ADDR   (NB_ADDR),
        .NB_DATA   (NB_DATA),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clock            (clock),
        .cpu_reset        (cpu_reset),
        .in_start         (in_start),
        .in_abort         (in_abort),
        .in_full_from_ram (in_full_from_ram),
        .in_data_from_ram (in_data_from_ram),
        .in_ready         (in_ready),
        .out_log_ram_run  (out_log_ram_run),
        .out_ram_read_addr(out_ram_read_addr),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_busy         (out_busy),
        .out_done         (out_done)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Edge counter used to measure word spacing.
    always @(posedge clock) cycle <= cycle + 1;

    // Capture RAM: word i holds 16'hA000+i, three edges from address to data.
    always @(posedge clock) begin
        ramPipe1         <= 16'hA000 + 16'(out_ram_read_addr);
        ramPipe2         <= ramPipe1;
        in_data_from_ram <= ramPipe2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: each run must deliver words 0..DEPTH-1 in order, hold a
    // stalled word unchanged, and close with exactly one done pulse.
    always @(negedge clock) begin
        if (cpu_reset || in_abort) begin
            expIdx      = 0;
            holdPending = 1'b0;
            lastXfer    = -1;
        end else begin
            if (holdPending) begin
                checkOutput("holdValid", 32'(out_valid), 32'd1);
                checkOutput("holdData", 32'(out_data), 32'(holdData));
                checkOutput("holdAddr", 32'(out_ram_read_addr), 32'(holdAddr));
            end
            holdPending = 1'b0;
            if (out_valid && in_ready) begin
                checkOutput("data", 32'(out_data), 32'(16'hA000 + expIdx));
                checkOutput("addr", 32'(out_ram_read_addr), 32'(expIdx));
                if (spacingCheck && lastXfer >= 0)
                    checkOutput("spacing", 32'(cycle - lastXfer), 32'(RD_LATENCY + 2));
                lastXfer = cycle;
                expIdx++;
            end else if (out_valid) begin
                holdPending = 1'b1;
                holdData    = out_data;
                holdAddr    = out_ram_read_addr;
            end
            if (out_done) begin
                checkOutput("wordCount", 32'(expIdx), 32'(DEPTH));
                checkOutput("doneRunLow", 32'(out_log_ram_run), 32'd0);
                doneCount++;
                expIdx   = 0;
                lastXfer = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic f, input logic a, input logic r);
        in_start         = s;
        in_full_from_ram = f;
        in_abort         = a;
        in_ready         = r;
    endtask

    task automatic startRun();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        checkOutput("busyLog", 32'(out_busy), 32'd1);
        checkOutput("runLog", 32'(out_log_ram_run), 32'd1);
    endtask

    // mode 0: ready held high, 1: 7-cycle stall at word 3, 2: random ready,
    // 3: random ready with full dropped mid-readout.
    task automatic driveUntilDone(input int mode);
        int  stallLeft = 7;
        int  dc0       = doneCount;
        bit  seenDone  = 1'b0;
        spacingCheck = (mode == 0);
        for (int c = 0; c < 600 && !seenDone; c++) begin
            case (mode)
                0: in_ready = 1'b1;
                1: begin
                    if (out_valid && expIdx == 3 && stallLeft > 0) begin
                        in_ready = 1'b0;
                        stallLeft--;
                    end else begin
                        in_ready = 1'b1;
                    end
                end
                default: in_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 3 && expIdx >= 4) in_full_from_ram = 1'b0;
            tick();
            if (out_done) seenDone = 1'b1;
        end
        checkOutput("doneSeen", 32'(seenDone), 32'd1);
        tick();
        checkOutput("runAfterDone", 32'(out_log_ram_run), 32'd0);
        checkOutput("busyAfterDone", 32'(out_busy), 32'd0);
        checkOutput("donePulseWidth", 32'(out_done), 32'd0);
        checkOutput("doneOnce", 32'(doneCount - dc0), 32'd1);
        if (mode == 1) checkOutput("stallUsed", 32'(stallLeft), 32'd0);
        spacingCheck     = 1'b0;
        in_full_from_ram = 1'b0;
        in_ready         = 1'b0;
    endtask

    task automatic runReadout(input int mode, input int gap);
        startRun();
        repeat (gap) tick();
        checkOutput("runBeforeFull", 32'(out_log_ram_run), 32'd1);
        checkOutput("validBeforeFull", 32'(out_valid), 32'd0);
        in_full_from_ram = 1'b1;
        driveUntilDone(mode);
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit hit;
        int dc0;
        cpu_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("rstRun", 32'(out_log_ram_run), 32'd0);
        checkOutput("rstAddr", 32'(out_ram_read_addr), 32'd0);
        checkOutput("rstData", 32'(out_data), 32'd0);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstBusy", 32'(out_busy), 32'd0);
        checkOutput("rstDone", 32'(out_done), 32'd0);
        cpu_reset = 1'b0;
        tick();

        $display("[TB] basic run, ready held high");
        runReadout(0, 20);

        $display("[TB] stall at word 3");
        runReadout(1, 20);

        $display("[TB] random ready runs");
        runReadout(2, $urandom_range(3, 20));
        runReadout(2, $urandom_range(3, 20));

        $display("[TB] full dropped mid-readout");
        runReadout(3, $urandom_range(3, 20));

        $display("[TB] abort during word 5");
        startRun();
        repeat (5) tick();
        in_full_from_ram = 1'b1;
        in_ready         = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (out_valid && expIdx == 5) hit = 1'b1;
            else tick();
        end
        checkOutput("abortReach", 32'(hit), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("abortValid", 32'(out_valid), 32'd0);
        checkOutput("abortRun", 32'(out_log_ram_run), 32'd0);
        checkOutput("abortBusy", 32'(out_busy), 32'd0);
        checkOutput("abortDone", 32'(out_done), 32'd0);
        dc0 = doneCount;
        repeat (20) tick();
        in_full_from_ram = 1'b0;
        checkOutput("abortNoDone", 32'(doneCount - dc0), 32'd0);
        checkOutput("abortIdle", 32'(out_busy), 32'd0);
        runReadout(0, 6);

        $display("[TB] reset during wait of word 2");
        startRun();
        repeat (4) tick();
        in_full_from_ram = 1'b1;
        in_ready         = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (!out_valid && out_busy && expIdx == 2) hit = 1'b1;
            else tick();
        end
        checkOutput("resetReach", 32'(hit), 32'd1);
        cpu_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("midRstRun", 32'(out_log_ram_run), 32'd0);
        checkOutput("midRstAddr", 32'(out_ram_read_addr), 32'd0);
        checkOutput("midRstData", 32'(out_data), 32'd0);
        checkOutput("midRstValid", 32'(out_valid), 32'd0);
        checkOutput("midRstBusy", 32'(out_busy), 32'd0);
        checkOutput("midRstDone", 32'(out_done), 32'd0);
        cpu_reset = 1'b0;
        in_start  = 1'b1;
        tick();
        in_start = 1'b0;
        checkOutput("startAfterRst", 32'(out_busy), 32'd1);
        repeat (3) tick();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        checkOutput("startInLogBusy", 32'(out_busy), 32'd1);
        checkOutput("startInLogValid", 32'(out_valid), 32'd0);
        repeat (5) tick();
        in_full_from_ram = 1'b1;
        dc0 = doneCount;
        driveUntilDone(0);
        repeat (60) tick();
        checkOutput("noSecondRunBusy", 32'(out_busy), 32'd0);
        checkOutput("noSecondRunDone", 32'(doneCount - dc0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
